register_file: RTL and testbench

//  - ARMv4 integer register file for the single-cycle datapath: 15 stored GPRs (R0-R14) plus R15 (PC+8) supplied externally.
//  - Two asynchronous read ports feed the ALU / shifter / store-data path.
//  - One synchronous write port takes the writeback result.
//  - Sits between the instruction decoder (register addresses) and the ALU/result mux.

---
 rtl/register_file_if.sv | 23 ++
 rtl/register_file.sv | 75 +++++++
 tb/tb_register_file.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register-file access bus: two combinational read ports, one write port, plus the externally owned R15 value.
interface register_file_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  WE3;
    logic [3:0]            A1;
    logic [3:0]            A2;
    logic [3:0]            A3;
    logic [DATA_WIDTH-1:0] WD3;
    logic [DATA_WIDTH-1:0] R15;
    logic [DATA_WIDTH-1:0] RD1;
    logic [DATA_WIDTH-1:0] RD2;

    modport master (
        output WE3, A1, A2, A3, WD3, R15,
        input  RD1, RD2
    );

    modport slave (
        input  WE3, A1, A2, A3, WD3, R15,
        output RD1, RD2
    );
endinterface

// File: rtl/register_file.sv
// ARMv4 register file: R0..R14 stored, R15 (PC+8) taken from the bus, two async reads, one sync write.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards WD3 to a read port addressing the register being written.
module register_file #(
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    register_file_if.slave rf
);
    localparam int NUM_REGS = 15;

    logic [DATA_WIDTH-1:0] regs_q [0:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [0:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] rd1_s;
    logic [DATA_WIDTH-1:0] rd2_s;
    logic                  wr_en_s;

    // Address 15 is the PC, owned by fetch, so it is never a write target.
    assign wr_en_s = rf.WE3 && (rf.A3 != 4'd15);

    // Next-state: only the addressed register picks up WD3.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en_s && (rf.A3 == 4'(i))) begin
                regs_d[i] = rf.WD3;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Storage update; reset wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read muxes: start from R15 and override with a stored register when the address matches.
    always_comb begin
        rd1_s = rf.R15;
        rd2_s = rf.R15;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rf.A1 == 4'(i)) begin
                rd1_s = regs_q[i];
            end else begin
                rd1_s = rd1_s;
            end
            if (rf.A2 == 4'(i)) begin
                rd2_s = regs_q[i];
            end else begin
                rd2_s = rd2_s;
            end
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_en_s && !rst && (rf.A1 == rf.A3)) begin
            rd1_s = rf.WD3;
        end else begin
            rd1_s = rd1_s;
        end
        if (wr_en_s && !rst && (rf.A2 == rf.A3)) begin
            rd2_s = rf.WD3;
        end else begin
            rd2_s = rd2_s;
        end
`endif
    end

    assign rf.RD1 = rd1_s;
    assign rf.RD2 = rd2_s;
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read data, a monitor samples and compares.
module tb_register_file;
    localparam int DW = 32;
`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    register_file_if #(.DATA_WIDTH(DW)) rf_if ();
    register_file #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .rf(rf_if));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        sb_q [$];
    event        sample_ev;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mdl [0:14];

    // Monitor: on each sample request, read the ports 1 time unit later and compare with the oldest expectation.
    initial begin
        forever begin
            @(sample_ev);
            #1;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=no_entry required=entry");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (rf_if.RD1 !== e.e1) begin
                    failures++;
                    $display("FAIL %s RD1 actual=%h required=%h", e.name, rf_if.RD1, e.e1);
                end
                checks++;
                if (rf_if.RD2 !== e.e2) begin
                    failures++;
                    $display("FAIL %s RD2 actual=%h required=%h", e.name, rf_if.RD2, e.e2);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.name = n;
        e.e1   = e1;
        e.e2   = e2;
        sb_q.push_back(e);
        ->sample_ev;
        #2;
    endtask

    function automatic logic [31:0] model_rd(input logic [3:0] a);
        if (a == 4'd15) return rf_if.R15;
        return mdl[a];
    endfunction

    task automatic rd(input string n, input logic [3:0] a1, input logic [3:0] a2);
        @(negedge clk);
        rf_if.A1 = a1;
        rf_if.A2 = a2;
        chk(n, model_rd(a1), model_rd(a2));
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        rf_if.WE3 = 1'b1;
        rf_if.A3  = a;
        rf_if.WD3 = d;
        @(negedge clk);
        rf_if.WE3 = 1'b0;
        if (a != 4'd15) mdl[a] = d;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 15; i++) mdl[i] = 32'h0000_0000;
    endtask

    initial begin
        clear_model();
        rst       = 1'b1;
        rf_if.WE3 = 1'b0;
        rf_if.A1  = 4'd0;
        rf_if.A2  = 4'd0;
        rf_if.A3  = 4'd0;
        rf_if.WD3 = 32'h0000_0000;
        rf_if.R15 = 32'h0000_0004;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        for (int a = 0; a < 15; a++) rd("reset_rd", 4'(a), 4'(a));
        rd("r15_after_reset", 4'd15, 4'd15);

        // Read during write on R1.
        @(negedge clk);
        rf_if.WE3 = 1'b1;
        rf_if.A3  = 4'd1;
        rf_if.WD3 = 32'hFFFF_FFFF;
        rf_if.A1  = 4'd1;
        rf_if.A2  = 4'd0;
        chk("rdw_before_edge", BYP ? 32'hFFFF_FFFF : 32'h0000_0000, 32'h0000_0000);
        @(negedge clk);
        rf_if.WE3 = 1'b0;
        mdl[1]    = 32'hFFFF_FFFF;
        chk("rdw_after_edge", 32'hFFFF_FFFF, 32'h0000_0000);
        rd("hold_1", 4'd1, 4'd1);
        rd("hold_2", 4'd1, 4'd1);

        // Several distinct patterns, including boundary registers R0 and R14.
        wr(4'd5, 32'h1357_9BDF);
        wr(4'd14, 32'hDEAD_BEEF);
        wr(4'd0, 32'h0000_0001);
        rd("pattern_a", 4'd5, 4'd14);
        rd("pattern_b", 4'd0, 4'd5);
        rd("same_addr", 4'd14, 4'd14);

        // WE3 low must not write.
        @(negedge clk);
        rf_if.A3  = 4'd5;
        rf_if.WD3 = 32'h0BAD_0BAD;
        rd("we3_low", 4'd5, 4'd0);

        // R15 passes through combinationally.
        @(negedge clk);
        rf_if.R15 = 32'h0000_0004;
        rf_if.A1  = 4'd1;
        rf_if.A2  = 4'd15;
        chk("r15_rd", 32'hFFFF_FFFF, 32'h0000_0004);
        rf_if.R15 = 32'h0000_000C;
        chk("r15_follow", 32'hFFFF_FFFF, 32'h0000_000C);

        // Writes to address 15 are ignored.
        wr(4'd15, 32'hF800_001F);
        @(negedge clk);
        rf_if.R15 = 32'h0000_0004;
        rf_if.A1  = 4'd15;
        rf_if.A2  = 4'd1;
        chk("r15_wr_ignored", 32'h0000_0004, 32'hFFFF_FFFF);
        for (int a = 0; a < 15; a++) rd("r15_wr_regs", 4'(a), 4'(14 - a));

        // Reset beats a concurrent write.
        @(negedge clk);
        rst       = 1'b1;
        rf_if.WE3 = 1'b1;
        rf_if.A3  = 4'd2;
        rf_if.WD3 = 32'h1234_5678;
        @(negedge clk);
        rst       = 1'b0;
        rf_if.WE3 = 1'b0;
        clear_model();
        rd("rst_priority", 4'd2, 4'd1);
        rd("post_reset", 4'd14, 4'd0);

        // Read of R3 while it is being written.
        wr(4'd3, 32'h1111_1111);
        @(negedge clk);
        rf_if.WE3 = 1'b1;
        rf_if.A3  = 4'd3;
        rf_if.WD3 = 32'hA5A5_A5A5;
        rf_if.A1  = 4'd3;
        rf_if.A2  = 4'd0;
        chk("bypass_before", BYP ? 32'hA5A5_A5A5 : 32'h1111_1111, 32'h0000_0000);
        @(negedge clk);
        rf_if.WE3 = 1'b0;
        mdl[3]    = 32'hA5A5_A5A5;
        chk("bypass_after", 32'hA5A5_A5A5, 32'h0000_0000);

        // No forwarding when WE3 is low.
        @(negedge clk);
        rf_if.A3  = 4'd3;
        rf_if.WD3 = 32'h0BAD_0BAD;
        rf_if.A1  = 4'd3;
        chk("no_fwd_we3_low", 32'hA5A5_A5A5, 32'h0000_0000);

        // No forwarding for a write to address 15.
        @(negedge clk);
        rf_if.WE3 = 1'b1;
        rf_if.A3  = 4'd15;
        rf_if.WD3 = 32'hF800_001F;
        rf_if.A1  = 4'd15;
        rf_if.R15 = 32'h0000_0008;
        chk("no_fwd_a3_15", 32'h0000_0008, 32'h0000_0000);
        @(negedge clk);
        rf_if.WE3 = 1'b0;

        // No forwarding while reset is asserted.
        wr(4'd4, 32'h0000_0077);
        @(negedge clk);
        rst       = 1'b1;
        rf_if.WE3 = 1'b1;
        rf_if.A3  = 4'd4;
        rf_if.WD3 = 32'h0000_0099;
        rf_if.A1  = 4'd4;
        rf_if.A2  = 4'd3;
        chk("no_fwd_in_reset", 32'h0000_0077, 32'hA5A5_A5A5);
        @(negedge clk);
        rst       = 1'b0;
        rf_if.WE3 = 1'b0;
        clear_model();
        chk("reset_clears", 32'h0000_0000, 32'h0000_0000);

        // Port 2 forwarding.
        @(negedge clk);
        rf_if.WE3 = 1'b1;
        rf_if.A3  = 4'd6;
        rf_if.WD3 = 32'hCAFE_F00D;
        rf_if.A1  = 4'd0;
        rf_if.A2  = 4'd6;
        chk("bypass_rd2", 32'h0000_0000, BYP ? 32'hCAFE_F00D : 32'h0000_0000);
        @(negedge clk);
        rf_if.WE3 = 1'b0;
        mdl[6]    = 32'hCAFE_F00D;
        chk("rd2_after", 32'h0000_0000, 32'hCAFE_F00D);

        // Drain the scoreboard with a bounded wait.
        for (int n = 0; n < 10; n++) begin
            if (sb_q.size() != 0) @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
